mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Parametrised multi-cycle multiply/divide unit for the processor datapath. It produces a double-width HI/LO result for MUL/DIV instructions, replacing the single-cycle ALU MUL/DIV path. Operands come from Y and the bus. Results are loaded into HI/LO, or into ZHI/ZLO, by the control unit once `done` pulses. It supports signed and unsigned modes, uses a start/done handshake, and has fixed latency.

## Interface
- WIDTH, 32, operand width in bits; legal range 2 to 64.
- CW, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

- clk  input  1  rising-edge clock
- clr  input  1  reset; synchronous, active-low
- start  input  1  request; sampled only when the unit is accepting
- op_div  input  1  0 = multiply, 1 = divide
- op_unsigned  input  1  0 = two's-complement operands, 1 = unsigned operands
- a  input  WIDTH  multiplicand or dividend (Y side)
- b  input  WIDTH  multiplier or divisor (bus side)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; hi/lo/div_by_zero are valid from this cycle
- hi  output  WIDTH  MUL: upper product half; DIV: remainder
- lo  output  WIDTH  MUL: lower product half; DIV: quotient
- div_by_zero  output  1  set with done when op_div=1 and b=0; cleared on next accept

## Operation
- States:
  - IDLE: accepting.
  - RUN: WIDTH iterations.
  - FIX: sign correction and result load.
  - DONE: done=1, accepting.
- Accept: start=1 in IDLE or DONE. Latch a, b, op_div, op_unsigned, and operand signs. Store magnitudes (two's-complement absolute value when signed; |MIN| is taken as an unsigned WIDTH-bit value). Counter = WIDTH-1. Go to RUN. Clear div_by_zero.
- start in RUN/FIX is ignored; there is no queueing.
- Multiply: radix-2 shift-add on magnitudes into a 2·WIDTH accumulator, one multiplier bit per RUN cycle.
- Divide: restoring division on magnitudes, one quotient bit per RUN cycle. Partial remainder is WIDTH+1 bits.
- RUN exits to FIX when the counter reaches 0 (exactly WIDTH RUN cycles).
- FIX, signed mode:
  - MUL: negate the 2·WIDTH product if the signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend (truncation toward zero).
  - Load hi/lo in the same cycle, then go to DONE.
- Divide by zero: the normal iteration runs, but FIX forces lo = all ones, hi = a (original, unmodified), div_by_zero = 1. Latency is unchanged.
- Signed MIN / -1: lo = MIN, hi = 0 (wraps, no flag).
- DONE → IDLE unconditionally, unless start=1, in which case it goes to RUN.
- hi/lo hold their value until the next FIX.

## Timing
- Start sampled at edge N:
  - busy=1 during cycles N+1 to N+WIDTH+1.
  - done=1 in cycle N+WIDTH+2 only.
  - Latency is WIDTH+2 cycles.
- busy=0 whenever done=1. Back-to-back throughput is one result per WIDTH+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (clr=0 at an edge), including mid-RUN/FIX:
  - Next cycle: state = IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0.
  - An in-flight operation is discarded.
  - clr has priority over start.

## Structure
- Package mul_div_pkg holds:
  - The state enum (IDLE, RUN, FIX, DONE).
  - Op-select constants OP_MUL=0 and OP_DIV=1.
  - The default WIDTH constant, 32.
- One sub-module, twos_abs: a WIDTH-wide combinational conditional negate (used for operand magnitudes and FIX).
- FSM, counter, and shift datapath live in mul_div_unit itself.

## Test plan
All cases use WIDTH=32.
- Signed MUL, a=0xFFFFFFFD (-3), b=7:
  - done exactly 34 cycles after start.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Unsigned MUL, a=b=0xFFFFFFFF:
  - hi=0xFFFFFFFE, lo=0x00000001.
- Signed MUL, a=b=0x80000000:
  - hi=0x40000000, lo=0.
- Signed DIV, a=0xFFFFFFF9 (-7), b=2:
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Unsigned DIV, a=0xFFFFFFF9, b=2:
  - lo=0x7FFFFFFC, hi=1.
- DIV by zero, a=0x00001234, b=0:
  - lo=0xFFFFFFFF, hi=0x00001234, div_by_zero=1 with done.
  - The next accepted start clears div_by_zero.
- Signed DIV, 0x80000000 / 0xFFFFFFFF:
  - lo=0x80000000, hi=0, div_by_zero=0.
- Control sequence:
  - start pulses during RUN are ignored (exactly one done).
  - clr=0 at RUN cycle 10 gives busy=0, hi=lo=0 next cycle.
  - start asserted during a DONE cycle is accepted and completes 34 cycles later.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
// Imported by the top-level datapath and its testbench.
package mul_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/mul_div_unit_twos_abs.sv
// Combinational conditional two's-complement negate.
// Used both for operand magnitudes and for sign correction of results.
module twos_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] result_o
);

    assign result_o = negate_i ? ((~value_i) + WIDTH'(1)) : value_i;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed/unsigned multiply and restoring divide, one bit per RUN cycle.
// Fixed latency of WIDTH+2 cycles from an accepted start to the done pulse.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_unsigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              op_div_q, op_div_d;
    logic              op_uns_q, op_uns_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic              b_zero_q, b_zero_d;
    logic [WIDTH-1:0]  a_orig_q, a_orig_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [WIDTH-1:0]  work_hi_q, work_hi_d;
    logic [WIDTH-1:0]  work_lo_q, work_lo_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              dbz_q, dbz_d;

    logic              a_neg_in, b_neg_in;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic              sign_diff, rem_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]  quot_fix, rem_fix;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic              div_ge;
    logic [WIDTH-1:0]  div_diff;

    assign a_neg_in = ~op_unsigned & a[WIDTH-1];
    assign b_neg_in = ~op_unsigned & b[WIDTH-1];

    twos_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value_i  (a),
        .negate_i (a_neg_in),
        .result_o (a_mag)
    );

    twos_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value_i  (b),
        .negate_i (b_neg_in),
        .result_o (b_mag)
    );

    assign sign_diff = ~op_uns_q & (a_neg_q ^ b_neg_q);
    assign rem_neg   = ~op_uns_q & a_neg_q;

    twos_abs #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value_i  ({work_hi_q, work_lo_q}),
        .negate_i (sign_diff),
        .result_o (prod_fix)
    );

    twos_abs #(.WIDTH(WIDTH)) u_fix_quot (
        .value_i  (work_lo_q),
        .negate_i (sign_diff),
        .result_o (quot_fix)
    );

    twos_abs #(.WIDTH(WIDTH)) u_fix_rem (
        .value_i  (work_hi_q),
        .negate_i (rem_neg),
        .result_o (rem_fix)
    );

    // Shift-add step: the carry out of the upper half becomes the new top bit after the shift.
    assign mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);

    // Restoring step: a set top bit of the shifted remainder always exceeds the divisor.
    assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_ge    = div_shift[WIDTH] | (div_shift[WIDTH-1:0] >= opnd_q);
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_div_d  = op_div_q;
        op_uns_d  = op_uns_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        b_zero_d  = b_zero_q;
        a_orig_d  = a_orig_q;
        opnd_d    = opnd_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = CW'(WIDTH - 1);
                    op_div_d  = op_div;
                    op_uns_d  = op_unsigned;
                    a_neg_d   = a_neg_in;
                    b_neg_d   = b_neg_in;
                    b_zero_d  = (b == '0);
                    a_orig_d  = a;
                    dbz_d     = 1'b0;
                    work_hi_d = '0;
                    if (op_div == OP_DIV) begin
                        opnd_d    = b_mag;
                        work_lo_d = a_mag;
                    end else begin
                        opnd_d    = a_mag;
                        work_lo_d = b_mag;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (op_div_q == OP_DIV) begin
                    if (div_ge) begin
                        work_hi_d = div_diff;
                        work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        work_hi_d = div_shift[WIDTH-1:0];
                        work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    work_hi_d = mul_sum[WIDTH:1];
                    work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                if (op_div_q == OP_MUL) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (b_zero_q) begin
                    lo_d  = '1;
                    hi_d  = a_orig_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            op_uns_q  <= 1'b0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            b_zero_q  <= 1'b0;
            a_orig_q  <= '0;
            opnd_q    <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            op_uns_q  <= op_uns_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            b_zero_q  <= b_zero_d;
            a_orig_q  <= a_orig_d;
            opnd_q    <= opnd_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit at WIDTH=32 with hand-computed results.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         clr;
    logic         start;
    logic         op_div;
    logic         op_unsigned;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int total;
    int bad;
    int lat;
    int doneCount;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .op_div      (op_div),
        .op_unsigned (op_unsigned),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits (bounded) for done; cycles counts edges including the accept edge.
    task automatic applyStimulus(input logic div, input logic uns, input logic [31:0] av,
                                 input logic [31:0] bv, output int cycles);
        op_div      = div;
        op_unsigned = uns;
        a           = av;
        b           = bv;
        start       = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        clr         = 1'b0;
        start       = 1'b0;
        op_div      = 1'b0;
        op_unsigned = 1'b0;
        a           = '0;
        b           = '0;

        repeat (3) tick();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset hi", hi, 32'h0);
        checkOutput("reset lo", lo, 32'h0);
        checkOutput("reset dbz", 32'(div_by_zero), 32'd0);
        clr = 1'b1;
        tick();

        applyStimulus(1'b0, 1'b0, 32'hFFFFFFFD, 32'd7, lat);
        checkOutput("smul latency", lat, 32'd34);
        checkOutput("smul busy at done", 32'(busy), 32'd0);
        checkOutput("smul hi", hi, 32'hFFFFFFFF);
        checkOutput("smul lo", lo, 32'hFFFFFFEB);
        tick();
        checkOutput("done one cycle", 32'(done), 32'd0);

        applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        checkOutput("umul hi", hi, 32'hFFFFFFFE);
        checkOutput("umul lo", lo, 32'h00000001);

        applyStimulus(1'b0, 1'b0, 32'h80000000, 32'h80000000, lat);
        checkOutput("smul min hi", hi, 32'h40000000);
        checkOutput("smul min lo", lo, 32'h00000000);

        applyStimulus(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, lat);
        checkOutput("sdiv latency", lat, 32'd34);
        checkOutput("sdiv lo", lo, 32'hFFFFFFFD);
        checkOutput("sdiv hi", hi, 32'hFFFFFFFF);

        applyStimulus(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, lat);
        checkOutput("udiv lo", lo, 32'h7FFFFFFC);
        checkOutput("udiv hi", hi, 32'h00000001);

        applyStimulus(1'b1, 1'b0, 32'h00001234, 32'h0, lat);
        checkOutput("dbz latency", lat, 32'd34);
        checkOutput("dbz lo", lo, 32'hFFFFFFFF);
        checkOutput("dbz hi", hi, 32'h00001234);
        checkOutput("dbz flag", 32'(div_by_zero), 32'd1);

        // Next request is accepted straight from DONE and must clear the flag.
        op_div      = 1'b1;
        op_unsigned = 1'b0;
        a           = 32'h80000000;
        b           = 32'hFFFFFFFF;
        start       = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("dbz cleared", 32'(div_by_zero), 32'd0);
        checkOutput("busy after accept", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        checkOutput("min/-1 latency", lat, 32'd34);
        checkOutput("min/-1 lo", lo, 32'h80000000);
        checkOutput("min/-1 hi", hi, 32'h00000000);
        checkOutput("min/-1 dbz", 32'(div_by_zero), 32'd0);
        tick();

        // Extra start pulses while running must not launch a second operation.
        op_div      = 1'b0;
        op_unsigned = 1'b1;
        a           = 32'hFFFFFFFF;
        b           = 32'd3;
        start       = 1'b1;
        tick();
        doneCount = 0;
        for (int i = 2; i <= 70; i++) begin
            start = (i == 6) || (i == 20);
            tick();
            if (done) doneCount++;
        end
        start = 1'b0;
        checkOutput("ignored starts", doneCount, 32'd1);
        checkOutput("umul3 hi", hi, 32'h00000002);
        checkOutput("umul3 lo", lo, 32'hFFFFFFFD);

        // Reset in the middle of RUN discards the operation and clears results.
        op_div      = 1'b0;
        op_unsigned = 1'b0;
        a           = 32'd5;
        b           = 32'd9;
        start       = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        clr = 1'b0;
        tick();
        checkOutput("midrun clr busy", 32'(busy), 32'd0);
        checkOutput("midrun clr done", 32'(done), 32'd0);
        checkOutput("midrun clr hi", hi, 32'h0);
        checkOutput("midrun clr lo", lo, 32'h0);
        clr = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) doneCount++;
        end
        checkOutput("discarded op", doneCount, 32'd0);

        // Start raised during the DONE cycle is accepted with full latency.
        applyStimulus(1'b0, 1'b1, 32'd6, 32'd7, lat);
        checkOutput("chain first lo", lo, 32'd42);
        applyStimulus(1'b1, 1'b1, 32'd100, 32'd7, lat);
        checkOutput("chain latency", lat, 32'd34);
        checkOutput("chain lo", lo, 32'd14);
        checkOutput("chain hi", hi, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
